// File: rtl/seven_seg_scan_controller.sv
// Multiplexed common-anode 7-segment scanner with a shared external decoder.
// Double-buffered display word; new values take effect only at frame boundaries.
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 50000,
    parameter int GAP        = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      load_valid_i,
    input  logic [4*NUM_DIGITS-1:0]   load_data_i,
    output logic                      load_ready_o,
    input  logic                      blank_lz_i,
    output logic [3:0]                dec_bin_o,
    input  logic [6:0]                dec_seg_i,
    output logic [6:0]                seg_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      frame_done_o
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_GAP_END  = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_SLOT_END = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   active_q, shadow_q;
    logic                      pending_q;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      frame_done_q;

    logic                      capture;
    logic                      frame_end;
    logic                      commit;
    logic [NUM_DIGITS-1:0]     blank;
    logic                      zero_run;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_OFF: begin
                cnt_d = '0;
                idx_d = '0;
                if (en_i) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (!en_i) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_GAP_END) begin
                        state_d = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                if (!en_i) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_SLOT_END) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // ---------------- display buffers ----------------
    assign frame_end = (state_q == S_SHOW) && (cnt_q == CNT_SLOT_END) && (idx_q == IDX_LAST);
    assign capture   = load_valid_i && !pending_q;
    // While the display is off there is no frame to protect, so commit at once.
    assign commit    = pending_q && (frame_end || (state_q == S_OFF));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (capture) begin
                shadow_q  <= load_data_i;
                pending_q <= 1'b1;
            end else if (commit) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
        end
    end

    // Digit k is a leading zero when it and every higher digit are zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (active_q[4*k +: 4] == 4'h0);
            blank[k] = blank_lz_i && zero_run;
        end
    end

    assign dec_bin_o = active_q[{idx_q, 2'b00} +: 4];

    // ---------------- output logic ----------------
    always_comb begin
        an_d  = '1;
        seg_d = 7'b1111111;
        if ((state_q == S_SHOW) && !blank[idx_q]) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = dec_seg_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_q  <= '1;
            seg_q <= 7'b1111111;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign load_ready_o = ~pending_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller (4 digits, DWELL=8, GAP=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seven_seg_scan_controller;

    localparam int ND = 4;
    localparam int DW = 8;
    localparam int GP = 2;

    logic          clk_i;
    logic          rst_i;
    logic          en_i;
    logic          load_valid_i;
    logic [15:0]   load_data_i;
    logic          load_ready_o;
    logic          blank_lz_i;
    logic [3:0]    dec_bin_o;
    logic [6:0]    dec_seg_i;
    logic [6:0]    seg_o;
    logic [3:0]    an_o;
    logic          frame_done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int jcur     = 0;

    seven_seg_scan_controller #(.NUM_DIGITS(ND), .DWELL(DW), .GAP(GP)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .blank_lz_i   (blank_lz_i),
        .dec_bin_o    (dec_bin_o),
        .dec_seg_i    (dec_seg_i),
        .seg_o        (seg_o),
        .an_o         (an_o),
        .frame_done_o (frame_done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference hex decoder, gfedcba, active low.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'b1000000;
            4'h1: seg_of = 7'b1111001;
            4'h2: seg_of = 7'b0100100;
            4'h3: seg_of = 7'b0110000;
            4'h4: seg_of = 7'b0011001;
            4'h5: seg_of = 7'b0010010;
            4'h6: seg_of = 7'b0000010;
            4'h7: seg_of = 7'b1111000;
            4'h8: seg_of = 7'b0000000;
            4'h9: seg_of = 7'b0010000;
            4'hA: seg_of = 7'b0001000;
            4'hB: seg_of = 7'b0000011;
            4'hC: seg_of = 7'b1000110;
            4'hD: seg_of = 7'b0100001;
            4'hE: seg_of = 7'b0000110;
            default: seg_of = 7'b0001110;
        endcase
    endfunction

    always_comb dec_seg_i = seg_of(dec_bin_o);

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Each sample shows the scan position j: cnt=j%8, digit=(j/8)%4; j<0 is still dark.
    task automatic run_checks(input int ticks, input logic [15:0] word, input logic [3:0] lit);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        int         c;
        int         d;
        for (int i = 0; i < ticks; i++) begin
            tick();
            ea = 4'b1111;
            es = 7'b1111111;
            ef = 1'b0;
            if (jcur >= 0) begin
                c  = jcur % DW;
                d  = (jcur / DW) % ND;
                ef = ((jcur % (ND*DW)) == ND*DW - 1);
                if (c >= GP && lit[d]) begin
                    ea[d] = 1'b0;
                    es    = seg_of(word[4*d +: 4]);
                end
            end
            n_checks += 3;
            if (an_o !== ea) begin
                n_fail++;
                $display("FAIL scan_an j=%0d got %b want %b", jcur, an_o, ea);
            end
            if (seg_o !== es) begin
                n_fail++;
                $display("FAIL scan_seg j=%0d got %b want %b", jcur, seg_o, es);
            end
            if (frame_done_o !== ef) begin
                n_fail++;
                $display("FAIL frame_done j=%0d got %b want %b", jcur, frame_done_o, ef);
            end
            jcur++;
        end
    endtask

    task automatic reload_off(input logic [15:0] word);
        en_i = 1'b0;
        tick();
        tick();
        load_valid_i = 1'b1;
        load_data_i  = word;
        tick();
        load_valid_i = 1'b0;
        tick();
        n_checks++;
        if (load_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_ready got %b want 1", load_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; load_valid_i = 1'b0; load_data_i = '0; blank_lz_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        n_checks += 5;
        if (an_o !== 4'b1111)          begin n_fail++; $display("FAIL reset_an got %b want 1111", an_o); end
        if (seg_o !== 7'b1111111)      begin n_fail++; $display("FAIL reset_seg got %b want 1111111", seg_o); end
        if (load_ready_o !== 1'b1)     begin n_fail++; $display("FAIL reset_ready got %b want 1", load_ready_o); end
        if (frame_done_o !== 1'b0)     begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done_o); end
        if (dec_bin_o !== 4'h0)        begin n_fail++; $display("FAIL reset_dec_bin got %h want 0", dec_bin_o); end
    endtask

    task automatic test_load_off();
        load_valid_i = 1'b1;
        load_data_i  = 16'h1234;
        tick();
        load_valid_i = 1'b0;
        n_checks++;
        if (load_ready_o !== 1'b0) begin n_fail++; $display("FAIL off_ready_low got %b want 0", load_ready_o); end
        tick();
        n_checks += 3;
        if (load_ready_o !== 1'b1) begin n_fail++; $display("FAIL off_ready_high got %b want 1", load_ready_o); end
        if (dec_bin_o !== 4'h4)    begin n_fail++; $display("FAIL off_commit_dec_bin got %h want 4", dec_bin_o); end
        if (an_o !== 4'b1111)      begin n_fail++; $display("FAIL off_an got %b want 1111", an_o); end
    endtask

    task automatic test_scan();
        en_i = 1'b1;
        jcur = -1;
        run_checks(40, 16'h1234, 4'b1111);
    endtask

    task automatic test_midframe_load();
        load_valid_i = 1'b1;
        load_data_i  = 16'h5678;
        run_checks(1, 16'h1234, 4'b1111);
        n_checks++;
        if (load_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_ready_low got %b want 0", load_ready_o); end
        load_data_i = 16'h9ABC;
        run_checks(1, 16'h1234, 4'b1111);
        load_valid_i = 1'b0;
        n_checks++;
        if (load_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_ready_pending got %b want 0", load_ready_o); end
        run_checks(64 - jcur, 16'h1234, 4'b1111);
        n_checks++;
        if (load_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after_commit got %b want 1", load_ready_o); end
        run_checks(32, 16'h5678, 4'b1111);
    endtask

    task automatic test_disable();
        run_checks(20, 16'h5678, 4'b1111);
        en_i = 1'b0;
        tick();
        n_checks++;
        if (an_o !== 4'b1011) begin n_fail++; $display("FAIL dis_still_lit got %b want 1011", an_o); end
        tick();
        n_checks += 4;
        if (an_o !== 4'b1111)       begin n_fail++; $display("FAIL dis_an got %b want 1111", an_o); end
        if (seg_o !== 7'b1111111)   begin n_fail++; $display("FAIL dis_seg got %b want 1111111", seg_o); end
        if (dec_bin_o !== 4'h8)     begin n_fail++; $display("FAIL dis_idx0 got %h want 8", dec_bin_o); end
        if (frame_done_o !== 1'b0)  begin n_fail++; $display("FAIL dis_frame_done got %b want 0", frame_done_o); end
        en_i = 1'b1;
        jcur = -1;
        run_checks(12, 16'h5678, 4'b1111);
    endtask

    task automatic test_blank_lz();
        blank_lz_i = 1'b1;
        reload_off(16'h0005);
        en_i = 1'b1; jcur = -1;
        run_checks(34, 16'h0005, 4'b0001);
        reload_off(16'h0000);
        en_i = 1'b1; jcur = -1;
        run_checks(34, 16'h0000, 4'b0001);
        reload_off(16'h0102);
        en_i = 1'b1; jcur = -1;
        run_checks(34, 16'h0102, 4'b0111);
        blank_lz_i = 1'b0;
        reload_off(16'h0000);
        en_i = 1'b1; jcur = -1;
        run_checks(34, 16'h0000, 4'b1111);
    endtask

    task automatic test_reset_midop();
        reload_off(16'h1234);
        en_i = 1'b1; jcur = -1;
        run_checks(10, 16'h1234, 4'b1111);
        load_valid_i = 1'b1;
        load_data_i  = 16'hABCD;
        tick();
        load_valid_i = 1'b0;
        n_checks++;
        if (load_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_pre_ready got %b want 0", load_ready_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        en_i  = 1'b0;
        n_checks += 4;
        if (load_ready_o !== 1'b1)  begin n_fail++; $display("FAIL rst_ready got %b want 1", load_ready_o); end
        if (dec_bin_o !== 4'h0)     begin n_fail++; $display("FAIL rst_dec_bin got %h want 0", dec_bin_o); end
        if (an_o !== 4'b1111)       begin n_fail++; $display("FAIL rst_an got %b want 1111", an_o); end
        if (seg_o !== 7'b1111111)   begin n_fail++; $display("FAIL rst_seg got %b want 1111111", seg_o); end
        tick();
        tick();
        n_checks += 2;
        if (dec_bin_o !== 4'h0)     begin n_fail++; $display("FAIL rst_discard got %h want 0", dec_bin_o); end
        if (load_ready_o !== 1'b1)  begin n_fail++; $display("FAIL rst_ready_hold got %b want 1", load_ready_o); end
    endtask

    initial begin
        test_reset();
        test_load_off();
        test_scan();
        test_midframe_load();
        test_disable();
        test_blank_lz();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
